// File: rtl/flow_merge_rr_if.sv
// flow_merge_rr_if: producer-side and accelerator-side signals of the flow
// merger. The slave modport is the merger's view; the master modport is the
// view of whatever drives the producers and models the accelerator.
interface flow_merge_rr_if #(
    parameter int FLUX   = 4,
    parameter int DATA_W = 8,
    parameter int TAG_W  = 2
);
    logic [FLUX*DATA_W-1:0]   src_din;
    logic [FLUX-1:0]          src_write;
    logic [FLUX-1:0]          src_full;
    logic [TAG_W+DATA_W-1:0]  dst_din;
    logic                     dst_write;
    logic [FLUX-1:0]          dst_full;
    logic [FLUX-1:0]          ovf;
    logic                     idle;

    modport slave (
        input  src_din, src_write, dst_full,
        output src_full, dst_din, dst_write, ovf, idle
    );

    modport master (
        output src_din, src_write, dst_full,
        input  src_full, dst_din, dst_write, ovf, idle
    );
endinterface

// File: rtl/flow_merge_rr.sv
// flow_merge_rr: merges FLUX per-flow pixel producers into one tagged write
// stream {flow tag, pixel}. Each flow has a 2-entry FIFO; a round-robin
// arbiter picks one eligible flow per cycle, honouring the accelerator's
// per-flow full vector and never writing the same flow on two consecutive
// cycles (covers the one-cycle lag of the accelerator's full flag).
// Optional build macro FLOW_MERGE_STATS_EN adds stat_cnt, one saturating
// 16-bit per-flow counter of emitted words.
module flow_merge_rr #(
    parameter int FLUX   = 4,
    parameter int DATA_W = 8,
    parameter int TAG_W  = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    flow_merge_rr_if.slave       bus
`ifdef FLOW_MERGE_STATS_EN
    ,
    output logic [FLUX*16-1:0]   stat_cnt
`endif
);

    localparam int PTR_W = (FLUX > 1) ? $clog2(FLUX) : 1;
    localparam logic [PTR_W-1:0] LAST_FLOW = PTR_W'(FLUX - 1);

    // Per-flow FIFO state: occupancy and two data slots, slot0 is the head.
    logic [1:0]        cnt  [FLUX];
    logic [DATA_W-1:0] mem0 [FLUX];
    logic [DATA_W-1:0] mem1 [FLUX];

    logic [FLUX-1:0]   full;
    logic [FLUX-1:0]   push;
    logic [FLUX-1:0]   pop;
    logic [FLUX-1:0]   elig;
    logic              any_data;

    // Arbitration state and search results.
    logic [PTR_W-1:0]  ptr;
    logic [PTR_W-1:0]  cand;
    logic [PTR_W-1:0]  grant_idx;
    logic              grant_vld;

    logic [TAG_W-1:0]  last_tag;
    assign last_tag = bus.dst_din[DATA_W +: TAG_W];

    // Full flags and occupancy summary, derived from registered counts only.
    always_comb begin
        // NOTE: every variable gets a default before any conditional logic so no latch can be inferred.
        full     = '0;
        any_data = 1'b0;
        for (int f = 0; f < FLUX; f++) begin
            full[f] = (cnt[f] == 2'd2);
            if (cnt[f] != 2'd0) begin
                any_data = 1'b1;
            end
        end
    end

    assign bus.src_full = full;
    assign push         = bus.src_write & ~full;

    // A flow competes only if it has data, the accelerator can take it, and it
    // was not the flow written on the previous cycle.
    always_comb begin
        elig = '0;
        for (int f = 0; f < FLUX; f++) begin
            elig[f] = (cnt[f] != 2'd0) && !bus.dst_full[f] &&
                      !(bus.dst_write && (last_tag == TAG_W'(f)));
        end
    end

    // Round-robin search starting one past the last granted flow.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        cand      = ptr;
        for (int i = 0; i < FLUX; i++) begin
            cand = (cand == LAST_FLOW) ? '0 : cand + PTR_W'(1);
            if (!grant_vld && elig[cand]) begin
                grant_vld = 1'b1;
                grant_idx = cand;
            end
        end
    end

    assign pop = grant_vld ? (FLUX'(1) << grant_idx) : '0;

    // FIFO occupancy: full is judged before the pop, so a push at count 2 is
    // always rejected even when the same flow is popped this cycle.
    always_ff @(posedge clk) begin
        // NOTE: registered state is updated with non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            for (int f = 0; f < FLUX; f++) begin
                cnt[f] <= 2'd0;
            end
        end else begin
            for (int f = 0; f < FLUX; f++) begin
                case ({push[f], pop[f]})
                    2'b10:   cnt[f] <= cnt[f] + 2'd1;
                    2'b01:   cnt[f] <= cnt[f] - 2'd1;
                    default: cnt[f] <= cnt[f];
                endcase
            end
        end
    end

    // FIFO data slots: a pop shifts slot1 into the head; a simultaneous push
    // lands in whichever slot becomes the tail so order is preserved.
    always_ff @(posedge clk) begin
        // NOTE: data slots carry no reset; the counts alone decide which slots are valid.
        for (int f = 0; f < FLUX; f++) begin
            if (pop[f]) begin
                if (cnt[f] == 2'd2) begin
                    mem0[f] <= mem1[f];
                end else if (push[f]) begin
                    mem0[f] <= bus.src_din[f*DATA_W +: DATA_W];
                end
            end else if (push[f]) begin
                if (cnt[f] == 2'd0) begin
                    mem0[f] <= bus.src_din[f*DATA_W +: DATA_W];
                end else begin
                    mem1[f] <= bus.src_din[f*DATA_W +: DATA_W];
                end
            end
        end
    end

    // Output register and round-robin pointer; dst_din holds when idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.dst_write <= 1'b0;
            bus.dst_din   <= '0;
            ptr           <= LAST_FLOW;
        end else if (grant_vld) begin
            bus.dst_write <= 1'b1;
            bus.dst_din   <= {TAG_W'(grant_idx), mem0[grant_idx]};
            ptr           <= grant_idx;
        end else begin
            bus.dst_write <= 1'b0;
        end
    end

    // Sticky overflow: a write attempted against a full FIFO is lost.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.ovf <= '0;
        end else begin
            bus.ovf <= bus.ovf | (bus.src_write & full);
        end
    end

    assign bus.idle = !any_data && !bus.dst_write;

`ifdef FLOW_MERGE_STATS_EN
    logic [15:0] stat_q [FLUX];

    // Saturating per-flow count of words emitted on dst.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int f = 0; f < FLUX; f++) begin
                stat_q[f] <= 16'd0;
            end
        end else begin
            for (int f = 0; f < FLUX; f++) begin
                if (pop[f] && (stat_q[f] != 16'hFFFF)) begin
                    stat_q[f] <= stat_q[f] + 16'd1;
                end
            end
        end
    end

    // Flatten the counters onto the output port, flow f at [f*16 +: 16].
    always_comb begin
        stat_cnt = '0;
        for (int f = 0; f < FLUX; f++) begin
            stat_cnt[f*16 +: 16] = stat_q[f];
        end
    end
`endif

endmodule

// File: tb/tb_flow_merge_rr.sv
// tb_flow_merge_rr: directed bench for flow_merge_rr (FLUX=4, DATA_W=8,
// TAG_W=2). A vector table covers reset, single-word latency and the
// four-flow round-robin burst; hand sequences cover single-flow streaming,
// downstream back-pressure, overflow and reset while data is buffered.
module tb_flow_merge_rr;

    localparam int FLUX   = 4;
    localparam int DATA_W = 8;
    localparam int TAG_W  = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;

    flow_merge_rr_if #(.FLUX(FLUX), .DATA_W(DATA_W), .TAG_W(TAG_W)) bus ();

`ifdef FLOW_MERGE_STATS_EN
    logic [FLUX*16-1:0] stat_cnt;
`endif

    flow_merge_rr #(.FLUX(FLUX), .DATA_W(DATA_W), .TAG_W(TAG_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus.slave)
`ifdef FLOW_MERGE_STATS_EN
        ,
        .stat_cnt (stat_cnt)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [9:0] rx [$];

    typedef struct packed {
        logic        rst;
        logic [3:0]  wr;
        logic [31:0] din;
        logic [3:0]  full;
        logic        e_dw;
        logic [9:0]  e_dd;
        logic [3:0]  e_sf;
        logic [3:0]  e_ovf;
        logic        e_idle;
    } vec_t;

    vec_t vecs [13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic vec_t mk(input logic r, input logic [3:0] wr, input logic [31:0] din,
                                input logic [3:0] full, input logic dw, input logic [9:0] dd,
                                input logic [3:0] sf, input logic [3:0] ov, input logic idl);
        vec_t v;
        v.rst = r; v.wr = wr; v.din = din; v.full = full;
        v.e_dw = dw; v.e_dd = dd; v.e_sf = sf; v.e_ovf = ov; v.e_idle = idl;
        return v;
    endfunction

    // One clock edge, then settle away from the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Tick and record any word written downstream.
    task automatic tick_rx();
        tick();
        if (bus.dst_write) rx.push_back(bus.dst_din);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.src_write = '0;
        tick();
        rst = 1'b0;
        rx.delete();
    endtask

    initial begin
        bus.src_din   = '0;
        bus.src_write = '0;
        bus.dst_full  = '0;

        //              rst  wr    din            full  dw  dd      sf    ovf   idle
        vecs[0]  = mk(1'b1, 4'h0, 32'h0,         4'h0, 0, 10'h000, 4'h0, 4'h0, 1);
        vecs[1]  = mk(1'b0, 4'h0, 32'h0,         4'h0, 0, 10'h000, 4'h0, 4'h0, 1);
        vecs[2]  = mk(1'b0, 4'h4, 32'h005A0000,  4'h0, 0, 10'h000, 4'h0, 4'h0, 0);
        vecs[3]  = mk(1'b0, 4'h0, 32'h0,         4'h0, 1, 10'h25A, 4'h0, 4'h0, 0);
        vecs[4]  = mk(1'b0, 4'h0, 32'h0,         4'h0, 0, 10'h25A, 4'h0, 4'h0, 1);
        vecs[5]  = mk(1'b1, 4'h0, 32'h0,         4'h0, 0, 10'h000, 4'h0, 4'h0, 1);
        vecs[6]  = mk(1'b0, 4'hF, 32'h13121110,  4'h0, 0, 10'h000, 4'h0, 4'h0, 0);
        vecs[7]  = mk(1'b0, 4'h0, 32'h0,         4'h0, 1, 10'h010, 4'h0, 4'h0, 0);
        vecs[8]  = mk(1'b0, 4'h0, 32'h0,         4'h0, 1, 10'h111, 4'h0, 4'h0, 0);
        vecs[9]  = mk(1'b0, 4'h0, 32'h0,         4'h0, 1, 10'h212, 4'h0, 4'h0, 0);
        vecs[10] = mk(1'b0, 4'h0, 32'h0,         4'h0, 1, 10'h313, 4'h0, 4'h0, 0);
        vecs[11] = mk(1'b0, 4'h0, 32'h0,         4'h0, 0, 10'h313, 4'h0, 4'h0, 1);
        vecs[12] = mk(1'b1, 4'h0, 32'h0,         4'h0, 0, 10'h000, 4'h0, 4'h0, 1);

        for (int i = 0; i < 13; i++) begin
            rst           = vecs[i].rst;
            bus.src_write = vecs[i].wr;
            bus.src_din   = vecs[i].din;
            bus.dst_full  = vecs[i].full;
            tick();
            check($sformatf("vec%0d_dst_write", i), bus.dst_write, vecs[i].e_dw);
            check($sformatf("vec%0d_dst_din", i),   bus.dst_din,   vecs[i].e_dd);
            check($sformatf("vec%0d_src_full", i),  bus.src_full,  vecs[i].e_sf);
            check($sformatf("vec%0d_ovf", i),       bus.ovf,       vecs[i].e_ovf);
            check($sformatf("vec%0d_idle", i),      bus.idle,      vecs[i].e_idle);
        end
        rst = 1'b0;
        bus.src_write = '0;

        // Flow 0 streams alone; producer respects src_full.
        begin
            logic [7:0] exp_q [$];
            int  sent = 0;
            int  got = 0;
            logic prev_dw = 1'b0;
            logic saw_full = 1'b0;
            do_reset();
            for (int c = 0; c < 24; c++) begin
                if (sent < 8 && !bus.src_full[0]) begin
                    bus.src_write = 4'h1;
                    bus.src_din   = {24'h0, 8'h40 + 8'(sent)};
                    exp_q.push_back(8'h40 + 8'(sent));
                    sent++;
                end else begin
                    bus.src_write = 4'h0;
                end
                tick();
                saw_full |= bus.src_full[0];
                if (bus.dst_write) begin
                    check("stream_back_to_back", {31'h0, prev_dw}, 32'h0);
                    if (exp_q.size() == 0) begin
                        check("stream_extra_word", bus.dst_din, 32'h3FF);
                    end else begin
                        check("stream_word", bus.dst_din, {2'b00, exp_q.pop_front()});
                    end
                    got++;
                end
                prev_dw = bus.dst_write;
            end
            bus.src_write = '0;
            check("stream_count", got, 8);
            check("stream_saw_full", {31'h0, saw_full}, 32'h1);
            check("stream_ovf0", bus.ovf, 4'h0);
            check("stream_idle", bus.idle, 1'b1);
        end

        // Flow 1 blocked downstream while flows 0 and 1 are loaded.
        do_reset();
        bus.dst_full  = 4'b0010;
        bus.src_write = 4'b0011;
        bus.src_din   = 32'h0000B0A0;
        tick_rx();
        bus.src_din   = 32'h0000B1A1;
        tick_rx();
        check("block_src_full", bus.src_full, 4'b0010);
        bus.src_write = '0;
        for (int c = 0; c < 6; c++) tick_rx();
        check("block_rx_count", rx.size(), 2);
        if (rx.size() == 2) begin
            check("block_rx0", rx[0], 10'h0A0);
            check("block_rx1", rx[1], 10'h0A1);
        end
        rx.delete();
        bus.dst_full = '0;
        for (int c = 0; c < 6; c++) tick_rx();
        check("release_rx_count", rx.size(), 2);
        if (rx.size() == 2) begin
            check("release_rx0", rx[0], 10'h1B0);
            check("release_rx1", rx[1], 10'h1B1);
        end

        // Flow 3 overflow with dst_full[3] held.
        do_reset();
        bus.dst_full  = 4'b1000;
        bus.src_write = 4'b1000;
        bus.src_din   = 32'hD0000000;
        tick_rx();
        check("ovf_full_after1", bus.src_full, 4'b0000);
        bus.src_din   = 32'hD1000000;
        tick_rx();
        check("ovf_full_after2", bus.src_full, 4'b1000);
        check("ovf_flag_after2", bus.ovf, 4'b0000);
        bus.src_din   = 32'hD2000000;
        tick_rx();
        check("ovf_flag_after3", bus.ovf, 4'b1000);
        bus.src_write = '0;
        bus.dst_full  = '0;
        for (int c = 0; c < 6; c++) tick_rx();
        check("ovf_rx_count", rx.size(), 2);
        if (rx.size() == 2) begin
            check("ovf_rx0", rx[0], 10'h3D0);
            check("ovf_rx1", rx[1], 10'h3D1);
        end
        check("ovf_sticky", bus.ovf, 4'b1000);
`ifdef FLOW_MERGE_STATS_EN
        check("stat_after_ovf", stat_cnt, 64'h0002_0000_0000_0000);
`endif
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("ovf_cleared_by_rst", bus.ovf, 4'b0000);

        // Reset while three flows hold data.
        do_reset();
        bus.dst_full  = 4'b0111;
        bus.src_write = 4'b0111;
        bus.src_din   = 32'h00C2C1C0;
        tick();
        bus.src_write = '0;
        tick();
        check("midrst_idle_before", bus.idle, 1'b0);
        rst = 1'b1;
        tick();
        check("midrst_dst_write", bus.dst_write, 1'b0);
        check("midrst_src_full", bus.src_full, 4'b0000);
        check("midrst_idle", bus.idle, 1'b1);
        check("midrst_dst_din", bus.dst_din, 10'h000);
`ifdef FLOW_MERGE_STATS_EN
        check("midrst_stat", stat_cnt, 64'h0);
`endif
        rst = 1'b0;
        bus.dst_full = '0;
        rx.delete();
        for (int c = 0; c < 4; c++) tick_rx();
        check("midrst_no_write", rx.size(), 0);
        check("midrst_idle_after", bus.idle, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
